// File: rtl/qcpu_serial_io_if.sv
// CPU-side register bus for qcpu_serial_io: 2-bit address, byte data,
// single-cycle write and read strobes, combinational read data.
interface qcpu_serial_io_if;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/qcpu_serial_io.sv
// Byte-wide serial peripheral: 8N1 UART transceiver plus mode-0 MSB-first SPI
// master behind a 4-register CPU bus (0 UART data, 1 status, 2 SPI data, 3 control).
module qcpu_serial_io #(
  parameter int UART_DIV = 7,
  parameter int SPI_HALF = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  qcpu_serial_io_if.slave    bus,
  output logic               txd,
  input  logic               rxd,
  output logic               sclk,
  output logic               sdo,
  input  logic               sdi,
  output logic               irq
);
  localparam int UW = $clog2(UART_DIV);
  localparam int SW = $clog2(SPI_HALF);
  localparam logic [UW-1:0] U_FULL = UW'(UART_DIV - 1);
  localparam logic [UW-1:0] U_HALF = UW'(UART_DIV / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SPI_HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          tx_busy;
  logic [9:0]    tx_sr;
  logic [UW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  logic          rx_s1, rx_s2;
  rx_state_t     rx_state, rx_state_nx;
  logic [UW-1:0] rx_cnt;
  logic [2:0]    rx_bitn;
  logic [7:0]    rx_sr, rx_buf;
  logic          rx_valid, rx_overrun, rx_frame_err;
  logic          rx_valid_nx, rx_overrun_nx, rx_frame_err_nx;
  logic          rx_tick, rx_done, rx_err;

  logic          spi_busy, spi_done;
  logic [7:0]    spi_sr;
  logic [SW-1:0] spi_cnt;
  logic [2:0]    spi_bitn;

  logic [1:0]    ctrl;
  logic          wr_tx, wr_spi, wr_ctrl, rd_rx, rd_spi;

  assign wr_tx   = bus.we && (bus.addr == 2'd0) && !tx_busy;
  assign wr_spi  = bus.we && (bus.addr == 2'd2) && !spi_busy;
  assign wr_ctrl = bus.we && (bus.addr == 2'd3);
  assign rd_rx   = bus.re && (bus.addr == 2'd0);
  assign rd_spi  = bus.re && (bus.addr == 2'd2);

  // UART TX: frame shifts out LSB first; idle value of all ones keeps txd high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_sr   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (wr_tx) begin
      tx_busy <= 1'b1;
      tx_sr   <= {1'b1, bus.wdata, 1'b0};
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == U_FULL) begin
        tx_cnt <= '0;
        tx_sr  <= {1'b1, tx_sr[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else                tx_bit  <= tx_bit + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + UW'(1);
      end
    end
  end

  assign txd = tx_sr[0];

  // UART RX: synchronizer and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_tick     = 1'b0;
    rx_done     = 1'b0;
    rx_err      = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_state_nx = RX_START;
      RX_START: if (rx_cnt == U_HALF) begin
        rx_tick     = 1'b1;
        rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (rx_cnt == U_FULL) begin
        rx_tick = 1'b1;
        if (rx_bitn == 3'd7) rx_state_nx = RX_STOP;
      end
      RX_STOP:  if (rx_cnt == U_FULL) begin
        rx_tick     = 1'b1;
        rx_done     = rx_s2;
        rx_err      = !rx_s2;
        rx_state_nx = RX_IDLE;
      end
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  // A completing byte outranks a same-cycle data read, so it is never lost.
  always_comb begin
    rx_valid_nx     = rd_rx ? 1'b0 : rx_valid;
    rx_overrun_nx   = rd_rx ? 1'b0 : rx_overrun;
    rx_frame_err_nx = rd_rx ? 1'b0 : rx_frame_err;
    if (rx_done) begin
      rx_overrun_nx = rx_overrun_nx | rx_valid_nx;
      rx_valid_nx   = 1'b1;
    end
    if (rx_err) rx_frame_err_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt       <= '0;
      rx_bitn      <= '0;
      rx_sr        <= '0;
      rx_buf       <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_cnt <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + UW'(1);
      if (rx_state != RX_DATA) rx_bitn <= '0;
      else if (rx_tick)        rx_bitn <= rx_bitn + 3'd1;
      if (rx_state == RX_DATA && rx_tick) rx_sr <= {rx_s2, rx_sr[7:1]};
      if (rx_done) rx_buf <= rx_sr;
      rx_valid     <= rx_valid_nx;
      rx_overrun   <= rx_overrun_nx;
      rx_frame_err <= rx_frame_err_nx;
    end
  end

  // SPI master: sample sdi on the rising phase, advance sdo on the falling phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy <= 1'b0;
      spi_done <= 1'b0;
      spi_sr   <= '0;
      spi_cnt  <= '0;
      spi_bitn <= '0;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
    end else begin
      if (rd_spi) spi_done <= 1'b0;
      if (wr_spi) begin
        spi_busy <= 1'b1;
        spi_sr   <= bus.wdata;
        spi_cnt  <= '0;
        spi_bitn <= '0;
        sclk     <= 1'b0;
        sdo      <= bus.wdata[7];
      end else if (spi_busy) begin
        if (spi_cnt == S_LAST) begin
          spi_cnt <= '0;
          if (!sclk) begin
            sclk   <= 1'b1;
            spi_sr <= {spi_sr[6:0], sdi};
          end else begin
            sclk <= 1'b0;
            if (spi_bitn == 3'd7) begin
              spi_busy <= 1'b0;
              spi_done <= 1'b1;
            end else begin
              spi_bitn <= spi_bitn + 3'd1;
              sdo      <= spi_sr[7];
            end
          end
        end else begin
          spi_cnt <= spi_cnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl <= '0;
    else if (wr_ctrl) ctrl <= bus.wdata[1:0];
  end

  always_comb begin
    bus.rdata = 8'h00;
    case (bus.addr)
      2'd0: bus.rdata = rx_buf;
      2'd1: bus.rdata = {3'b000, rx_frame_err, rx_overrun, spi_busy, rx_valid, tx_busy};
      2'd2: bus.rdata = spi_sr;
      2'd3: bus.rdata = {6'b000000, ctrl};
      default: bus.rdata = 8'h00;
    endcase
  end

  assign irq = (rx_valid & ctrl[0]) | (spi_done & ctrl[1]);
endmodule

// File: tb/tb_qcpu_serial_io.sv
// Scoreboard bench for qcpu_serial_io: stimulus queues expected bus reads, pin
// snapshots, UART frames and SPI bytes; independent monitors pop and compare.
module tb_qcpu_serial_io;
  localparam int UART_DIV = 7;
  localparam int SPI_HALF = 5;

  logic clk, rst_n, txd, rxd, sclk, sdo, sdi, irq;
  qcpu_serial_io_if bus();

  qcpu_serial_io #(.UART_DIV(UART_DIV), .SPI_HALF(SPI_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .txd(txd), .rxd(rxd),
    .sclk(sclk), .sdo(sdo), .sdi(sdi), .irq(irq));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         compared = 0;
  int         mismatched = 0;
  string      exp_name_q[$];
  logic [7:0] exp_val_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] spi_q[$];
  logic       snap = 1'b0;
  logic       mon_en = 1'b1;
  logic [7:0] slave_sr = 8'h00;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    cyc(1);
    bus.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    exp_name_q.push_back(nm); exp_val_q.push_back(e);
    bus.addr = a; bus.re = 1'b1;
    cyc(1);
    bus.re = 1'b0;
  endtask

  // Pin snapshot layout: {irq, sdo, sclk, txd}
  task automatic pins(input logic [7:0] e, input string nm);
    exp_name_q.push_back(nm); exp_val_q.push_back(e);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      cyc(UART_DIV);
    end
    rxd = 1'b1;
  endtask

  // Bus read / pin snapshot monitor
  string      rm_nm;
  logic [7:0] rm_ev;
  always @(negedge clk) begin
    if (bus.re || snap) begin
      if (exp_val_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_sample: got 0x%02h expected none", bus.rdata);
      end else begin
        rm_nm = exp_name_q.pop_front();
        rm_ev = exp_val_q.pop_front();
        check(rm_nm, snap ? {4'h0, irq, sdo, sclk, txd} : bus.rdata, rm_ev);
      end
    end
  end

  // UART TX frame monitor: captures 10*UART_DIV samples from the start edge
  logic       tx_cap = 1'b0;
  int         tx_n, tx_terr;
  logic       tx_smp [0:10*UART_DIV-1];
  logic [9:0] tx_frm;
  always @(negedge clk) begin
    if (!rst_n) tx_cap = 1'b0;
    else begin
      if (!tx_cap && mon_en && txd === 1'b0) begin
        tx_cap = 1'b1; tx_n = 0;
      end
      if (tx_cap) begin
        tx_smp[tx_n] = txd; tx_n++;
        if (tx_n == 10*UART_DIV) begin
          tx_cap = 1'b0; tx_terr = 0;
          for (int b = 0; b < 10; b++) begin
            tx_frm[b] = tx_smp[b*UART_DIV];
            for (int j = 1; j < UART_DIV; j++)
              if (tx_smp[b*UART_DIV+j] !== tx_frm[b]) tx_terr++;
          end
          if (tx_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL tx_unexpected_frame: got 0x%02h expected none", tx_frm[8:1]);
          end else begin
            check("tx_data", tx_frm[8:1], tx_q.pop_front());
            check("tx_start_stop_timing", {5'd0, tx_frm[0], tx_frm[9], tx_terr == 0}, 8'h03);
          end
        end
      end
    end
  end

  // SPI monitor: sdo captured where sclk has risen, phase widths in clocks
  logic       sp_prev = 1'b0;
  int         sp_run = 0, sp_bits = 0, sp_terr = 0;
  logic [7:0] sp_byte = 8'h00;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      sp_bits = 0; sp_terr = 0; sp_run = 0;
    end else if (sclk === sp_prev) begin
      sp_run++;
    end else begin
      if (sclk) begin
        if (sp_bits > 0 && sp_run != SPI_HALF) sp_terr++;
        sp_byte = {sp_byte[6:0], sdo};
        sp_bits++;
      end else begin
        if (sp_run != SPI_HALF) sp_terr++;
        if (sp_bits == 8) begin
          if (spi_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL spi_unexpected_transfer: got 0x%02h expected none", sp_byte);
          end else begin
            check("spi_sdo", sp_byte, spi_q.pop_front());
            check("spi_sclk_phase_errors", 8'(sp_terr), 8'h00);
          end
          sp_bits = 0; sp_terr = 0;
        end
      end
      sp_run = 1;
    end
    sp_prev = sclk;
  end

  // SPI slave model: shifts its next bit out on each sclk falling edge
  always @(negedge sclk) begin
    slave_sr = {slave_sr[6:0], 1'b0};
    sdi = slave_sr[7];
  end

  initial begin
    repeat (20000) @(posedge clk);
    compared++; mismatched++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    rst_n = 1'b0; rxd = 1'b1; sdi = 1'b0;
    bus.addr = 2'd0; bus.wdata = 8'h00; bus.we = 1'b0; bus.re = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    pins(8'h01, "reset_pins");
    bus_rd(2'd1, 8'h00, "reset_status");
    bus_rd(2'd3, 8'h00, "reset_ctrl");
    bus_rd(2'd0, 8'h00, "reset_rxbuf");
    bus_rd(2'd2, 8'h00, "reset_spibuf");

    bus_wr(2'd3, 8'hFF);
    bus_rd(2'd3, 8'h03, "ctrl_readback");

    // UART TX with an ignored busy write, then tx_busy clear edge
    tx_q.push_back(8'h69);
    bus_wr(2'd0, 8'h69);
    bus_wr(2'd0, 8'hAA);
    bus_rd(2'd1, 8'h01, "tx_busy_set");
    cyc(66);
    bus_rd(2'd1, 8'h01, "tx_busy_at_68");
    bus_rd(2'd1, 8'h01, "tx_busy_at_69");
    bus_rd(2'd1, 8'h00, "tx_busy_clear_at_70");

    // Back-to-back TX concurrent with a received byte
    tx_q.push_back(8'h3C);
    bus_wr(2'd0, 8'h3C);
    uart_send(8'h53, 1'b1);
    pins(8'h09, "rx_irq_high");
    bus_rd(2'd1, 8'h02, "rx_valid_status");
    bus_rd(2'd0, 8'h53, "rx_data");
    pins(8'h01, "rx_irq_dropped");
    bus_rd(2'd1, 8'h00, "rx_status_cleared");

    // Framing error leaves buffer untouched
    uart_send(8'hA5, 1'b0);
    bus_rd(2'd1, 8'h10, "rx_frame_err");
    bus_rd(2'd0, 8'h53, "rx_buf_after_frame_err");
    bus_rd(2'd1, 8'h00, "frame_err_cleared");

    // Overrun keeps the second byte
    uart_send(8'h11, 1'b1);
    cyc(2);
    uart_send(8'hC3, 1'b1);
    bus_rd(2'd1, 8'h0A, "rx_overrun_status");
    pins(8'h09, "overrun_irq");
    bus_rd(2'd0, 8'hC3, "rx_overrun_data");
    bus_rd(2'd1, 8'h00, "overrun_cleared");

    // SPI transfer with an ignored busy write
    slave_sr = 8'h27;
    sdi = slave_sr[7];
    spi_q.push_back(8'h69);
    bus_wr(2'd2, 8'h69);
    bus_wr(2'd2, 8'hFF);
    bus_rd(2'd1, 8'h04, "spi_busy_set");
    cyc(76);
    bus_rd(2'd1, 8'h04, "spi_busy_at_78");
    bus_rd(2'd1, 8'h04, "spi_busy_at_79");
    bus_rd(2'd1, 8'h00, "spi_busy_clear_at_80");
    pins(8'h0D, "spi_done_irq");
    bus_rd(2'd2, 8'h27, "spi_rx_data");
    pins(8'h05, "spi_irq_dropped");

    // Asynchronous reset in the middle of a TX frame and an SPI transfer
    mon_en = 1'b0;
    bus_wr(2'd0, 8'h00);
    bus_wr(2'd2, 8'h81);
    cyc(16);
    pins(8'h02, "mid_transfer_pins");
    #1 rst_n = 1'b0;
    pins(8'h01, "async_reset_pins");
    bus_rd(2'd1, 8'h00, "async_reset_status");
    rst_n = 1'b1;
    bus_rd(2'd0, 8'h00, "post_reset_rxbuf");
    bus_rd(2'd2, 8'h00, "post_reset_spibuf");
    bus_rd(2'd3, 8'h00, "post_reset_ctrl");
    pins(8'h01, "post_reset_pins");

    cyc(5);
    check("read_queue_left", 8'(exp_val_q.size()), 8'h00);
    check("tx_queue_left", 8'(tx_q.size()), 8'h00);
    check("spi_queue_left", 8'(spi_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
